// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the counter control stage.
package count_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/count_ctrl_if.sv
// Button/switch inputs and counter strobes between the control stage and its neighbours.
interface count_ctrl_if
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             btn_up;
    logic             btn_load;
    logic             auto_en;
    logic [WIDTH-1:0] sw_value;
    logic [WIDTH-1:0] entrada;
    logic             load;
    logic             countUp;

    modport master (
        output btn_up, btn_load, auto_en, sw_value,
        input  entrada, load, countUp
    );

    modport slave (
        input  btn_up, btn_load, auto_en, sw_value,
        output entrada, load, countUp
    );

endinterface

// File: rtl/count_ctrl_btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw push-button.
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned    CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic           sync1;
    logic           sync2;
    deb_state_e     state;
    deb_state_e     state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           press_nxt;
    logic           level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            press <= 1'b0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
            level <= level_nxt;
        end
    end

    // cnt holds the number of consecutive cycles the synced level has disagreed
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    if (DEB_CYCLES <= 1) begin
                        state_nxt = STABLE_HI;
                        press_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_HI;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    if (DEB_CYCLES <= 1) begin
                        state_nxt = STABLE_LO;
                    end else begin
                        state_nxt = WAIT_LO;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
    end

endmodule

// File: rtl/count_ctrl.sv
// Control stage for the 8-bit up counter: debounced buttons, auto-count prescaler, load/count arbitration.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned PRESCALE   = 10
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.slave  bus
);

    localparam int unsigned   PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic             up_press;
    logic             up_level;
    logic             load_press;
    logic             load_level;
    logic [PW-1:0]    presc;
    logic             tick_c;
    logic             req_c;
    logic             pending;
    logic [WIDTH-1:0] entrada_q;
    logic             load_q;
    logic             count_q;
    logic [1:0]       unused_levels;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_up),
        .level (up_level),
        .press (up_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_load),
        .level (load_level),
        .press (load_press)
    );

    assign unused_levels = {up_level, load_level};

    assign tick_c = bus.auto_en && (presc == PRE_LAST);
    assign req_c  = up_press | tick_c;

    // Free-running only while auto_en is high; dropping it restarts the period
    always_ff @(posedge clk) begin
        if (rst || !bus.auto_en) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Load wins a collision; the displaced count request is replayed next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            entrada_q <= '0;
            load_q    <= 1'b0;
            count_q   <= 1'b0;
            pending   <= 1'b0;
        end else if (load_press) begin
            entrada_q <= bus.sw_value;
            load_q    <= 1'b1;
            count_q   <= 1'b0;
            pending   <= req_c;
        end else begin
            load_q    <= 1'b0;
            count_q   <= req_c | pending;
            pending   <= 1'b0;
        end
    end

    assign bus.entrada = entrada_q;
    assign bus.load    = load_q;
    assign bus.countUp = count_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: scenario table, corner sequences, randomized run against a reference model.
module tb_count_ctrl;

    localparam int unsigned W   = 8;
    localparam int          DEB = 4;
    localparam int          PRE = 10;
    localparam int          NV  = 16;

    logic clk;
    logic rst;

    count_ctrl_if #(.WIDTH(W)) bus ();

    count_ctrl #(.WIDTH(W), .DEB_CYCLES(DEB), .PRESCALE(PRE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int seg_cu;
    int seg_ld;

    // Reference model state: delay line, debounced level with run length, enable age
    logic         m_d1 [2];
    logic         m_d2 [2];
    logic         m_lvl [2];
    logic         m_press [2];
    int           m_run [2];
    int           m_en_cnt;
    logic         m_pend;
    logic         m_load;
    logic         m_cu;
    logic [W-1:0] m_entrada;

    typedef struct {
        logic         rst;
        logic         up;
        logic         ld;
        logic         auto_en;
        logic [W-1:0] sw;
        int           cycles;
        int           exp_cu;
        int           exp_ld;
        logic [W-1:0] exp_ent;
    } vec_t;

    vec_t vecs [NV];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic raw [2];
        logic newp [2];
        logic tick;
        logic req;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_lvl[b] = 1'b0;
                m_press[b] = 1'b0; m_run[b] = 0;
            end
            m_en_cnt = 0; m_pend = 1'b0; m_load = 1'b0; m_cu = 1'b0; m_entrada = '0;
        end else begin
            raw[0] = bus.btn_up;
            raw[1] = bus.btn_load;
            for (int b = 0; b < 2; b++) begin
                newp[b] = 1'b0;
                if (m_d2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_lvl[b] = m_d2[b];
                        m_run[b] = 0;
                        newp[b]  = m_lvl[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_d2[b] = m_d1[b];
                m_d1[b] = raw[b];
            end
            tick     = bus.auto_en && ((m_en_cnt % PRE) == PRE - 1);
            m_en_cnt = bus.auto_en ? m_en_cnt + 1 : 0;
            req      = m_press[0] || tick;
            if (m_press[1]) begin
                m_load = 1'b1; m_entrada = bus.sw_value; m_cu = 1'b0; m_pend = req;
            end else begin
                m_load = 1'b0; m_cu = req || m_pend; m_pend = 1'b0;
            end
            m_press[0] = newp[0];
            m_press[1] = newp[1];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check8("model_load", 8'(bus.load), 8'(m_load));
        check8("model_countUp", 8'(bus.countUp), 8'(m_cu));
        check8("model_entrada", bus.entrada, m_entrada);
        check8("exclusive_strobes", 8'(bus.load & bus.countUp), 8'h00);
        if (bus.load === 1'b1) seg_ld++;
        if (bus.countUp === 1'b1) seg_cu++;
    endtask

    initial begin
        int first;
        checks = 0; failures = 0; seg_cu = 0; seg_ld = 0;
        rst = 1'b1;
        bus.btn_up = 1'b1; bus.btn_load = 1'b1; bus.auto_en = 1'b0; bus.sw_value = 8'hA5;
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_lvl[b] = 1'b0; m_press[b] = 1'b0; m_run[b] = 0;
        end
        m_en_cnt = 0; m_pend = 1'b0; m_load = 1'b0; m_cu = 1'b0; m_entrada = '0;

        //             rst   up    ld    auto  sw     cyc cu ld ent
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA5,  2, 0, 0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 12, 1, 1, 8'hA5};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 12, 0, 0, 8'hA5};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C,  3, 0, 0, 8'hA5};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h3C,  1, 0, 0, 8'hA5};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C,  3, 0, 0, 8'hA5};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h3C,  2, 0, 0, 8'hA5};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 10, 0, 1, 8'h3C};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 10, 0, 0, 8'h3C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 20, 1, 0, 8'h3C};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 10, 0, 0, 8'h3C};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 35, 3, 0, 8'h3C};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 15, 0, 0, 8'h3C};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hC3,  9, 0, 0, 8'h3C};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hC3,  1, 1, 0, 8'h3C};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3,  5, 0, 0, 8'h3C};

        for (int v = 0; v < NV; v++) begin
            rst = vecs[v].rst;
            bus.btn_up = vecs[v].up;
            bus.btn_load = vecs[v].ld;
            bus.auto_en = vecs[v].auto_en;
            bus.sw_value = vecs[v].sw;
            seg_cu = 0;
            seg_ld = 0;
            repeat (vecs[v].cycles) cycle();
            check_int($sformatf("vec%0d_countUp_pulses", v), seg_cu, vecs[v].exp_cu);
            check_int($sformatf("vec%0d_load_pulses", v), seg_ld, vecs[v].exp_ld);
            check8($sformatf("vec%0d_entrada", v), bus.entrada, vecs[v].exp_ent);
        end

        // Clean press: strobe on the 7th edge after the first sample, exactly once
        bus.btn_up = 1'b1;
        seg_cu = 0;
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            cycle();
            if (bus.countUp === 1'b1 && first == 0) first = e;
        end
        check_int("press_latency_edge", first, DEB + 3);
        check_int("press_pulse_count", seg_cu, 1);
        bus.btn_up = 1'b0;
        repeat (10) cycle();

        // Load press lands on the same edge as an auto tick
        bus.auto_en = 1'b1;
        bus.sw_value = 8'hFF;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) bus.btn_load = 1'b1;
            cycle();
            if (e == 9) check8("coll_n-1_load", 8'(bus.load), 8'h00);
            if (e == 10) begin
                check8("coll_n_load", 8'(bus.load), 8'h01);
                check8("coll_n_entrada", bus.entrada, 8'hFF);
                check8("coll_n_countUp", 8'(bus.countUp), 8'h00);
            end
            if (e == 11) begin
                check8("coll_n+1_countUp", 8'(bus.countUp), 8'h01);
                check8("coll_n+1_load", 8'(bus.load), 8'h00);
            end
        end
        bus.auto_en = 1'b0;
        bus.btn_load = 1'b0;
        repeat (10) cycle();

        // Up press lands on the same edge as an auto tick: one strobe only
        bus.auto_en = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) bus.btn_up = 1'b1;
            cycle();
            if (e == 9)  check8("merge_n-1_countUp", 8'(bus.countUp), 8'h00);
            if (e == 10) check8("merge_n_countUp", 8'(bus.countUp), 8'h01);
            if (e == 11) check8("merge_n+1_countUp", 8'(bus.countUp), 8'h00);
        end
        bus.auto_en = 1'b0;
        bus.btn_up = 1'b0;
        repeat (10) cycle();

        // Reset in the middle of a debounce discards the partial count
        bus.btn_up = 1'b1;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (bus.countUp === 1'b1 && first == 0) first = e;
        end
        check_int("post_reset_press_edge", first, DEB + 3);
        check8("post_reset_entrada", bus.entrada, 8'h00);
        bus.btn_up = 1'b0;
        repeat (10) cycle();

        // Randomized bouncing buttons, auto toggling and occasional resets
        for (int i = 0; i < 3000; i++) begin
            int fr;
            fr = (((i / 250) % 2) == 1) ? 20 : 4;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, fr - 1) == 0) bus.btn_up = ~bus.btn_up;
            if ($urandom_range(0, fr - 1) == 0) bus.btn_load = ~bus.btn_load;
            if ($urandom_range(0, 59) == 0) bus.auto_en = ~bus.auto_en;
            bus.sw_value = W'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Upstream control stage for the 8-bit up counter. Turns two raw push-buttons, an auto-count enable and an 8-bit switch bank into the clean single-cycle `load` and `countUp` strobes and the `entrada` value that the counter consumes. Handles synchronisation, debouncing, edge detection, an auto-increment prescaler, and load/count arbitration. `load` and `countUp` are never high in the same cycle.

## Interface
- `WIDTH`, 8: width of `sw_value` and `entrada`.
- `DEB_CYCLES`, 4: consecutive stable cycles required to accept a button level change (≥1).
- `PRESCALE`, 10: auto-count period in clock cycles (≥2).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_up` in 1: raw asynchronous "count" button.
- `btn_load` in 1: raw asynchronous "load" button.
- `auto_en` in 1: level; enables periodic auto-count (synchronous to `clk`).
- `sw_value` in WIDTH: value to load (synchronous, sampled on load event).
- `entrada` out WIDTH: registered load value; held between loads.
- `load` out 1: one-cycle load strobe.
- `countUp` out 1: one-cycle increment strobe.

## Operation
- Reset (`rst`=1 at an edge): `entrada`=0, `load`=0, `countUp`=0, synchronisers=0, debounced levels=0, debounce counters=0, prescaler=0, pending=0.
- Each button: 2-flop synchroniser, then debounce FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO→WAIT_HI when synced=1; WAIT_HI counts cycles with synced=1; any synced=0 returns to STABLE_LO with counter cleared; counter reaching DEB_CYCLES → STABLE_HI, emit press event (one cycle).
  - Symmetric for release (WAIT_LO → STABLE_LO); release emits nothing.
  - A button held high across reset release is treated as a new press (debounced level resets to 0).
- Auto mode: while `auto_en`=1, prescaler counts 0..PRESCALE-1 and wraps; tick when value = PRESCALE-1. `auto_en`=0 forces prescaler to 0 synchronously; no tick.
- Count request `req` = up press event OR auto tick; coincident events merge into one request (one increment).
- Arbitration, per cycle:
  - load event: `load`=1, `entrada`←`sw_value` (same edge), `countUp`=0, pending←`req`. Any pending count from before is discarded (load wins).
  - no load event: `countUp`=`req` OR pending; pending←0. Coincident `req` and pending merge into one strobe.
- Pending is 1 bit; only set in a load cycle, so at most one increment follows a load.

## Timing
- All outputs registered; no combinational input→output path.
- Button latency: strobe asserted at edge DEB_CYCLES+3 counted from the first edge that samples the new raw level (2 sync + DEB_CYCLES debounce + 1 output register), given a bounce-free input.
- Glitch of fewer than DEB_CYCLES synced cycles: no strobe.
- Auto tick to `countUp`: 1 cycle. First tick after `auto_en` rises occurs PRESCALE cycles later.
- Load with coincident request: `load` at cycle n, `countUp` at cycle n+1.
- `rst` mid-operation: next edge returns everything to reset values; pending and partial debounce counts are lost.
- `entrada` changes only on a load event; otherwise stable.

## Structure
- Package `count_ctrl_pkg`: debounce state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO) and default `WIDTH` constant.
- Sub-module `btn_debounce` (synchroniser + FSM + counter, outputs debounced level and press pulse), instantiated twice.
- Top holds prescaler, arbitration, pending flag, `entrada` register.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with buttons high and `sw_value`=0xA5 → `entrada`=0x00, `load`=`countUp`=0 throughout reset.
- Clean press: `btn_up` 0→1 held 20 cycles (DEB_CYCLES=4) → exactly one `countUp` pulse, 7 edges after first sample; none on release.
- Bounce: `btn_load` pulses high for 3 cycles, low 1, high 3 → no `load`; then held high 10 cycles → one `load`, `entrada`=`sw_value`=0x3C.
- Auto: `auto_en`=1 for 35 cycles (PRESCALE=10) → `countUp` at cycles 10, 20, 30 after enable; drop `auto_en` → no further strobes, prescaler restarts from 0 on re-enable.
- Collision: load press event and auto tick in same cycle with `sw_value`=0xFF → `load`=1, `entrada`=0xFF at n; `countUp`=1 at n+1; never both high.
- Merge: up press event coincident with auto tick → single one-cycle `countUp`.
